// File: rtl/multi_button_debouncer_pkg.sv
// Shared types, default parameters and helpers for the keypad debouncer.
package button_pkg;

  // Per-channel hold tracker: released, held before long-press, auto-repeating.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } hold_state_t;

  localparam int DEF_N_CH         = 4;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_MAX_COUNT    = 16;
  localparam int DEF_LONG_COUNT   = 500;
  localparam int DEF_REPEAT_COUNT = 100;

  // Counter width able to hold 0..value-1, never narrower than one bit.
  function automatic int cnt_width(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/multi_button_debouncer_if.sv
// Bundle of tick, raw keys and all per-channel debounced outputs.
interface multi_button_debouncer_if #(
  parameter int N_CH = 4
);

  logic            tick;
  logic [N_CH-1:0] in;
  logic [N_CH-1:0] out;
  logic [N_CH-1:0] edj;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] long_press;
  logic [N_CH-1:0] repeat_pulse;

  // Keypad side: supplies the tick and raw pins, consumes key events.
  modport master (
    output tick, in,
    input  out, edj, rise, fall, long_press, repeat_pulse
  );

  // Debouncer side.
  modport slave (
    input  tick, in,
    output out, edj, rise, fall, long_press, repeat_pulse
  );

endinterface

// File: rtl/multi_button_debouncer_channel.sv
// One key: synchroniser, tick-gated debounce counter and long-press/repeat FSM.
module debounce_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int MAX_COUNT    = DEF_MAX_COUNT,
  parameter int LONG_COUNT   = DEF_LONG_COUNT,
  parameter int REPEAT_COUNT = DEF_REPEAT_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic in_raw,
  output logic out,
  output logic edj,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int CW = cnt_width(MAX_COUNT);
  localparam int HW = cnt_width(LONG_COUNT);
  localparam int RW = cnt_width(REPEAT_COUNT);

  localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_COUNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_COUNT - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_COUNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   in_s;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          rise_d, fall_d;

  hold_state_t   state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          long_d, rpt_d;

  logic edj_q, rise_q, fall_q, long_q, rpt_q;

  assign in_s = sync_q[SYNC_STAGES-1];

  // Metastability chain for the asynchronous key pin; runs every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], in_raw};
  end

  // Debounce decision: accept the new level after MAX_COUNT consecutive differing ticks.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (tick) begin
      if (cnt_q == CNT_LAST) begin
        out_d  = in_s;
        cnt_d  = '0;
        rise_d = in_s & ~out_q;
        fall_d = ~in_s & out_q;
      end else if (in_s != out_q) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Hold FSM next state: a release always wins and silences further pulses.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    if (fall_d) begin
      state_d = IDLE;
      hold_d  = '0;
      rep_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise_d) begin
            state_d = HOLD;
            hold_d  = '0;
            rpt_d   = 1'b1;
          end
        end
        HOLD: begin
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              long_d  = 1'b1;
              rpt_d   = 1'b1;
              hold_d  = '0;
              rep_d   = '0;
              state_d = REPEAT;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
        end
        REPEAT: begin
          if (tick) begin
            if (rep_q == REP_LAST) begin
              rpt_d = 1'b1;
              rep_d = '0;
            end else begin
              rep_d = rep_q + RW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
          rep_d   = '0;
        end
      endcase
    end
  end

  // Debounce counter, level and single-clock edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      edj_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      edj_q  <= rise_d | fall_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Hold FSM state, its counters and its single-clock pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rep_q   <= '0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
    end
  end

  assign out          = out_q;
  assign edj          = edj_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign long_press   = long_q;
  assign repeat_pulse = rpt_q;

endmodule

// File: rtl/multi_button_debouncer.sv
// N independent key debouncers sharing one tick enable.
module multi_button_debouncer
  import button_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int MAX_COUNT    = DEF_MAX_COUNT,
  parameter int LONG_COUNT   = DEF_LONG_COUNT,
  parameter int REPEAT_COUNT = DEF_REPEAT_COUNT
) (
  input logic                     clk,
  input logic                     rst,
  multi_button_debouncer_if.slave bus
);

  // One channel per key; no interaction between channels.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .MAX_COUNT    (MAX_COUNT),
      .LONG_COUNT   (LONG_COUNT),
      .REPEAT_COUNT (REPEAT_COUNT)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .tick         (bus.tick),
      .in_raw       (bus.in[i]),
      .out          (bus.out[i]),
      .edj          (bus.edj[i]),
      .rise         (bus.rise[i]),
      .fall         (bus.fall[i]),
      .long_press   (bus.long_press[i]),
      .repeat_pulse (bus.repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench for multi_button_debouncer with small counts.
module tb_multi_button_debouncer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  multi_button_debouncer_if #(.N_CH(4)) bus ();

  multi_button_debouncer #(
    .N_CH         (4),
    .SYNC_STAGES  (2),
    .MAX_COUNT    (4),
    .LONG_COUNT   (8),
    .REPEAT_COUNT (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] in_v, input logic tick_v);
    bus.in   = in_v;
    bus.tick = tick_v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] e_out, input logic [3:0] e_rise,
                          input logic [3:0] e_fall, input logic [3:0] e_long, input logic [3:0] e_rpt);
    checkOutput({tag, " out"},          bus.out,          e_out);
    checkOutput({tag, " edj"},          bus.edj,          e_rise | e_fall);
    checkOutput({tag, " rise"},         bus.rise,         e_rise);
    checkOutput({tag, " fall"},         bus.fall,         e_fall);
    checkOutput({tag, " long_press"},   bus.long_press,   e_long);
    checkOutput({tag, " repeat_pulse"}, bus.repeat_pulse, e_rpt);
  endtask

  initial begin
    // Reset: outputs cleared asynchronously, before any clock edge.
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b1);
    #1;
    checkAll("reset", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    step();
    step();
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      checkAll($sformatf("idle e%0d", e), 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    end

    // Clean press on ch0: accepted at edge 6, released before long-press.
    applyStimulus(4'b0001, 1'b1);
    for (int e = 1; e <= 7; e++) begin
      step();
      checkAll($sformatf("press0 e%0d", e), (e >= 6) ? 4'b0001 : 4'b0000,
               (e == 6) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000,
               (e == 6) ? 4'b0001 : 4'b0000);
    end
    applyStimulus(4'b0000, 1'b1);
    for (int e = 1; e <= 10; e++) begin
      step();
      checkAll($sformatf("release0 e%0d", e), (e < 6) ? 4'b0001 : 4'b0000,
               4'b0000, (e == 6) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000);
    end

    // Bounce on ch1: three edges high is too short to be accepted.
    applyStimulus(4'b0010, 1'b1);
    for (int e = 1; e <= 3; e++) begin
      step();
      checkAll($sformatf("bounce1 e%0d", e), 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    end
    applyStimulus(4'b0000, 1'b1);
    for (int e = 4; e <= 10; e++) begin
      step();
      checkAll($sformatf("bounce1 e%0d", e), 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    end

    // Long hold on ch2: rise 6, long 14, repeats every 3 edges after.
    applyStimulus(4'b0100, 1'b1);
    for (int e = 1; e <= 30; e++) begin
      step();
      checkAll($sformatf("hold2 e%0d", e), (e >= 6) ? 4'b0100 : 4'b0000,
               (e == 6) ? 4'b0100 : 4'b0000, 4'b0000,
               (e == 14) ? 4'b0100 : 4'b0000,
               (e == 6 || (e >= 14 && (e - 14) % 3 == 0)) ? 4'b0100 : 4'b0000);
    end
    // Release while repeating: repeats at 32 and 35 still occur, fall at 36, then silence.
    applyStimulus(4'b0000, 1'b1);
    for (int r = 1; r <= 12; r++) begin
      step();
      checkAll($sformatf("release2 r%0d", r), (r < 6) ? 4'b0100 : 4'b0000,
               4'b0000, (r == 6) ? 4'b0100 : 4'b0000, 4'b0000,
               (r == 2 || r == 5) ? 4'b0100 : 4'b0000);
    end

    // Tick every 4th clock on ch3: accepted on the 4th qualifying tick, edge 16.
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(4'b1000, (e % 4 == 0) ? 1'b1 : 1'b0);
      step();
      checkAll($sformatf("slowtick3 e%0d", e), (e >= 16) ? 4'b1000 : 4'b0000,
               (e == 16) ? 4'b1000 : 4'b0000, 4'b0000, 4'b0000,
               (e == 16) ? 4'b1000 : 4'b0000);
    end
    applyStimulus(4'b0000, 1'b1);
    for (int e = 1; e <= 8; e++) begin
      step();
      checkAll($sformatf("release3 e%0d", e), (e < 6) ? 4'b1000 : 4'b0000,
               4'b0000, (e == 6) ? 4'b1000 : 4'b0000, 4'b0000, 4'b0000);
    end

    // Drive ch2 into REPEAT, then reset between edges.
    applyStimulus(4'b0100, 1'b1);
    for (int e = 1; e <= 16; e++) begin
      step();
      checkAll($sformatf("prereset2 e%0d", e), (e >= 6) ? 4'b0100 : 4'b0000,
               (e == 6) ? 4'b0100 : 4'b0000, 4'b0000,
               (e == 14) ? 4'b0100 : 4'b0000,
               (e == 6 || e == 14) ? 4'b0100 : 4'b0000);
    end
    #2;
    rst = 1'b1;
    #1;
    checkAll("midreset", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    #2;
    rst = 1'b0;
    // Key still held after reset counts as a fresh press.
    for (int e = 1; e <= 8; e++) begin
      step();
      checkAll($sformatf("postreset2 e%0d", e), (e >= 6) ? 4'b0100 : 4'b0000,
               (e == 6) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000,
               (e == 6) ? 4'b0100 : 4'b0000);
    end

    // Simultaneous press on ch0/ch1 lands on the same edge as ch2 long-press.
    applyStimulus(4'b0111, 1'b1);
    for (int e = 1; e <= 6; e++) begin
      step();
      checkAll($sformatf("multi e%0d", e), (e >= 6) ? 4'b0111 : 4'b0100,
               (e == 6) ? 4'b0011 : 4'b0000, 4'b0000,
               (e == 6) ? 4'b0100 : 4'b0000,
               (e == 6) ? 4'b0111 : 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_button_debouncer.md
# multi_button_debouncer

Parametrised N-channel debouncer for the calculator keypad. It generalises the single-channel debouncer with four additions: an input synchroniser, a shared tick enable for ms-scale debounce, asynchronous reset, and per-channel long-press and auto-repeat detection. It sits between the raw key pins and the key decoder/entry logic. Each channel supplies debounced level, edge pulses, and a repeat pulse usable directly as "key accepted".

## Interface
- N_CH, 4: number of independent button channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- MAX_COUNT, 16: stable ticks required to accept a level change (≥2).
- LONG_COUNT, 500: ticks after accepted press until long_press (≥2).
- REPEAT_COUNT, 100: ticks between auto-repeat pulses after long_press (≥2).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  counter enable; tie 1 to count every clk.
- in  in  N_CH  raw, asynchronous, noisy button levels.
- out  out  N_CH  debounced level.
- edj  out  N_CH  1-clk pulse on either edge of out.
- rise  out  N_CH  1-clk pulse on out 0→1.
- fall  out  N_CH  1-clk pulse on out 1→0.
- long_press  out  N_CH  1-clk pulse once per press after LONG_COUNT ticks held.
- repeat_pulse  out  N_CH  1-clk pulse on rise, on long_press, then every REPEAT_COUNT ticks while held.

## Operation
- Channels are fully independent. No cross-channel priority or arbitration.
- Synchroniser: a SYNC_STAGES-deep flop chain that runs every clk regardless of tick. Its last stage is in_s.
- Debounce counter, width $clog2(MAX_COUNT), advances only on clk edges with tick=1:
  - If cnt==MAX_COUNT-1: out<=in_s, cnt<=0. edj/rise/fall are set from (in_s vs old out).
  - Else if in_s!=out: cnt++.
  - Else: cnt<=0 (hysteresis; any return to the old level restarts the count).
- All pulse outputs default to 0 every clk edge, so every pulse is exactly one clk wide even with a slow tick.
- Hold FSM per channel, states IDLE, HOLD, REPEAT:
  - IDLE→HOLD on rise. hold_cnt<=0. repeat_pulse asserts with rise.
  - HOLD: each tick, hold_cnt++. At a tick with hold_cnt==LONG_COUNT-1: long_press=1, repeat_pulse=1, rep_cnt<=0, →REPEAT.
  - REPEAT: each tick, rep_cnt++. At a tick with rep_cnt==REPEAT_COUNT-1: repeat_pulse=1, rep_cnt<=0.
  - fall in any state → IDLE. No long_press or repeat_pulse on that edge or later.
- Counter widths: hold_cnt is $clog2(LONG_COUNT), rep_cnt is $clog2(REPEAT_COUNT). Neither counter ever wraps, because each is cleared at its terminal count.
- Reset: synchroniser, counters, and all outputs go to 0 and FSM goes to IDLE, immediately and asynchronously. A button already held at reset release is treated as a new press.

## Timing
- With tick=1, out and rise change on edge SYNC_STAGES+MAX_COUNT, counting the first edge that samples the new level as edge 1.
- long_press is LONG_COUNT ticks after rise. Subsequent repeat_pulses are every REPEAT_COUNT ticks.
- Each pulse is exactly one clk wide. edj coincides with rise or fall.
- Simultaneous rise on several channels: all are reported in the same cycle.
- A bounce shorter than MAX_COUNT ticks produces no output activity.

## Structure
- Shared package button_pkg holds:
  - the hold_state_t enum (IDLE, HOLD, REPEAT);
  - default parameter constants;
  - a cnt_width function returning $clog2 of a value, minimum 1.
- Sub-module debounce_channel implements synchroniser, debounce, and the hold FSM for one bit. The top instantiates it N_CH times via generate and shares tick across channels.

## Test plan
Bench parameters: N_CH=4, SYNC_STAGES=2, MAX_COUNT=4, LONG_COUNT=8, REPEAT_COUNT=3.
- Clean press, tick=1: in[0] 0→1 sampled at edge 1 and held → out[0], rise[0], edj[0], repeat_pulse[0] at edge 6, each 1 clk. Channels 1–3 stay at 0.
- Bounce: in[1] high for 3 edges then low → out[1] stays 0, and no pulses appear on any output.
- Long hold: in[2] held 30 edges → rise at edge 6; long_press and repeat_pulse at edge 14; repeat_pulse at edges 17, 20, 23, 26, 29.
- Release in REPEAT: in[2] drops during the long-hold scenario → fall[2] and edj[2] 6 edges later. No further repeat_pulse. FSM returns to IDLE.
- Tick gating: tick=1 every 4th clk, clean press → rise after 4 qualifying ticks plus synchroniser delay. Pulse width is 1 clk, not 4.
- Async reset mid-REPEAT: rst pulsed between edges → all outputs 0 before the next edge. With in[2] still high after reset release → rise[2] at edge 6 after release.
